// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants for the round-robin arbiter
package arb_pkg;

    localparam int NREQ             = 8;
    localparam int IDW              = 3;
    localparam int HOLD_MAX_DEFAULT = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/decoder3to8.sv
// rtl/decoder3to8.sv - 3-to-8 one-hot decoder
module decoder3to8 (
    input  logic [2:0] a,
    output logic [7:0] y
);

    assign y = 8'b0000_0001 << a;

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with hold-time preemption
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT,
    parameter int CW       = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            grant_valid,
    output logic            preempt
);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    logic [0:0]      state;
    logic [IDW-1:0]  last_id;
    logic [CW-1:0]   hold_cnt;
    logic [NREQ-1:0] owner_onehot;
    logic [NREQ-1:0] others;
    logic [IDW-1:0]  win_all;
    logic [IDW-1:0]  win_others;
    logic            own_req;
    logic            timeout;

    // First set bit at or after last+1, wrapping; iterating downward lets the nearest bit win.
    function automatic logic [IDW-1:0] rr_winner(input logic [NREQ-1:0] r,
                                                 input logic [IDW-1:0]  last);
        logic [IDW-1:0] idx;
        logic [IDW-1:0] result;
        result = last;
        for (int k = NREQ; k >= 1; k--) begin
            idx = last + IDW'(k);
            if (r[idx]) result = idx;
        end
        return result;
    endfunction

    decoder3to8 u_dec (
        .a (grant_id),
        .y (owner_onehot)
    );

    assign grant      = owner_onehot & {NREQ{grant_valid}};
    assign own_req    = req[grant_id];
    assign others     = req & ~owner_onehot;
    assign timeout    = (hold_cnt == HOLD_LAST);
    assign win_all    = rr_winner(req, last_id);
    assign win_others = rr_winner(others, last_id);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant_id    <= '0;
            last_id     <= IDW'(NREQ - 1);
            hold_cnt    <= '0;
            grant_valid <= 1'b0;
            preempt     <= 1'b0;
        end else begin
            preempt <= 1'b0;
            if (state == ST_IDLE) begin
                if (|req) begin
                    grant_id    <= win_all;
                    last_id     <= win_all;
                    grant_valid <= 1'b1;
                    hold_cnt    <= '0;
                    state       <= ST_BUSY;
                end
            end else begin
                // Release is checked before timeout so a coinciding drop never flags preempt.
                if (!own_req) begin
                    hold_cnt <= '0;
                    if (|others) begin
                        grant_id <= win_others;
                        last_id  <= win_others;
                    end else begin
                        grant_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end else if (timeout) begin
                    hold_cnt <= '0;
                    if (|others) begin
                        grant_id <= win_others;
                        last_id  <= win_others;
                        preempt  <= 1'b1;
                    end
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - scoreboard bench for rr_arbiter8
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       preempt;

    typedef struct {
        logic       valid;
        logic [2:0] id;
        logic       pre;
        int         tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   tag_n;
    event async_ev;

    rr_arbiter8 #(.HOLD_MAX(4), .CW(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .preempt     (preempt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push_exp(input logic v, input logic [2:0] id, input logic pre);
        exp_t e;
        e.valid = v;
        e.id    = id;
        e.pre   = pre;
        e.tag   = tag_n;
        tag_n++;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rn, input logic [7:0] r,
                        input logic v, input logic [2:0] id, input logic pre);
        @(negedge clk);
        rst_n = rn;
        req   = r;
        push_exp(v, id, pre);
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
    endtask

    // Monitor: one expectation is consumed per sample point
    initial begin
        exp_t       e;
        logic [7:0] eg;
        forever begin
            @(posedge clk or async_ev);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                eg = e.valid ? (8'd1 << e.id) : 8'd0;
                checks++;
                if (grant !== eg || grant_id !== e.id || grant_valid !== e.valid || preempt !== e.pre) begin
                    errors++;
                    $display("FAIL step%0d: got grant=%h id=%0d valid=%b preempt=%b, want grant=%h id=%0d valid=%b preempt=%b",
                             e.tag, grant, grant_id, grant_valid, preempt, eg, e.id, e.valid, e.pre);
                end
            end
        end
    end

    initial begin
        logic [7:0] m;
        checks = 0;
        errors = 0;
        tag_n  = 0;
        rst_n  = 1'b0;
        req    = 8'h00;

        // reset then idle
        repeat (3) step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        repeat (2) step(1'b1, 8'h00, 1'b0, 3'd0, 1'b0);

        // single requester
        step(1'b1, 8'h08, 1'b1, 3'd3, 1'b0);
        step(1'b1, 8'h00, 1'b0, 3'd3, 1'b0);
        step(1'b1, 8'h00, 1'b0, 3'd3, 1'b0);

        // round-robin fairness, zero-bubble handoff
        do_reset();
        step(1'b1, 8'hFF, 1'b1, 3'd0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 8'hFF, 1'b1, 3'(k), 1'b0);
            m = 8'hFF & ~(8'h01 << k);
            step(1'b1, m, 1'b1, 3'((k + 1) % 8), 1'b0);
        end

        // hold timeout with two requesters
        do_reset();
        repeat (4) step(1'b1, 8'h03, 1'b1, 3'd0, 1'b0);
        step(1'b1, 8'h03, 1'b1, 3'd1, 1'b1);
        repeat (3) step(1'b1, 8'h03, 1'b1, 3'd1, 1'b0);
        step(1'b1, 8'h03, 1'b1, 3'd0, 1'b1);
        step(1'b1, 8'h03, 1'b1, 3'd0, 1'b0);
        repeat (8) step(1'b1, 8'h01, 1'b1, 3'd0, 1'b0);

        // release on the timeout cycle
        do_reset();
        step(1'b1, 8'h01, 1'b1, 3'd0, 1'b0);
        repeat (3) step(1'b1, 8'h21, 1'b1, 3'd0, 1'b0);
        step(1'b1, 8'h20, 1'b1, 3'd5, 1'b0);
        step(1'b1, 8'h20, 1'b1, 3'd5, 1'b0);

        // asynchronous reset mid-grant
        step(1'b1, 8'h00, 1'b0, 3'd5, 1'b0);
        step(1'b1, 8'h40, 1'b1, 3'd6, 1'b0);
        step(1'b1, 8'h40, 1'b1, 3'd6, 1'b0);
        @(negedge clk);
        req = 8'hC1;
        #1;
        rst_n = 1'b0;
        push_exp(1'b0, 3'd0, 1'b0);
        -> async_ev;
        #3;
        rst_n = 1'b1;
        push_exp(1'b1, 3'd0, 1'b0);
        step(1'b1, 8'hC1, 1'b1, 3'd0, 1'b0);
        step(1'b1, 8'hC0, 1'b1, 3'd6, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
